// File: rtl/load_store_unit.sv
// Load/store unit: one word-wide data-memory transaction per start, with byte-lane
// steering, store replication, alignment/legality checks and a bounded memory wait.
module load_store_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] load_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q;
  logic [2:0]  f3_q;      // funct3 of the access in flight, selects load extension
  logic [1:0]  lo_q;      // byte offset within the word
  logic [31:0] wd_cnt_q;  // REQ cycles spent without mem_ready

  logic        access_ok;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Legality and alignment of the access presented with start.
  always_comb begin
    logic legal;
    logic aligned;
    if (is_store) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    // funct3[1:0] encodes size for every legal code (LBU/LHU share it with LB/LH)
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    access_ok = legal && aligned;
  end

  // Store data replication and byte-lane write enables.
  always_comb begin
    st_wdata = rs2_data;
    st_wmask = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_data[7:0]}};
        st_wmask = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_data[15:0]}};
        st_wmask = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2_data;
        st_wmask = 4'b1111;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    case (lo_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      wd_cnt_q  <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            f3_q <= funct3;
            lo_q <= addr[1:0];
            busy <= 1'b1;
            if (access_ok) begin
              state_q   <= StReq;
              wd_cnt_q  <= 32'd0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= is_store ? st_wdata : 32'd0;
              mem_wmask <= is_store ? st_wmask : 4'b0000;
            end else begin
              // Rejected before touching memory
              state_q <= StDone;
              done    <= 1'b1;
              fault   <= 1'b1;
            end
          end
        end
        StReq: begin
          if (mem_ready) begin
            state_q   <= StDone;
            done      <= 1'b1;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            if (!mem_we) begin
              load_data <= ld_ext;
            end
          end else if ((TIMEOUT != 0) && (wd_cnt_q == TIMEOUT - 1)) begin
            // Memory never answered; abort with load_data untouched
            state_q   <= StDone;
            done      <= 1'b1;
            fault     <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
          end else begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          fault   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
